// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
//  Module   : wb_write_queue
//  Purpose  : In-order write-back queue feeding the register-block write port.
//             Two producers (ALU results, MEM load results) push destination /
//             data pairs. Entries retire one per cycle into a registered
//             output stage (regwrite/writereg/writedata). Every pending
//             destination, whether queued or in the output stage, is reported
//             to decode as a hazard.
//  Ports    : clk, rst_n (synchronous, active-low)
//             alu_valid/alu_ready/alu_reg/alu_data  - ALU producer
//             mem_valid/mem_ready/mem_reg/mem_data  - load producer (priority)
//             hold                                  - freeze retirement
//             regwrite/writereg/writedata           - register-block write
//             readreg1/readreg2, hazard1/hazard2    - decode hazard query
//             count                                 - queued entries
//             fwd1_data/fwd2_data                   - only with WB_BYPASS_EN
//  Config   : define WB_BYPASS_EN to add forwarding outputs carrying the data
//             of the youngest pending write to each read address.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 32,
    parameter int RW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [RW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [RW-1:0] mem_reg,
    input  logic [DW-1:0] mem_data,
    input  logic          hold,
    output logic          regwrite,
    output logic [RW-1:0] writereg,
    output logic [DW-1:0] writedata,
    input  logic [RW-1:0] readreg1,
    input  logic [RW-1:0] readreg2,
    output logic          hazard1,
    output logic          hazard2,
`ifdef WB_BYPASS_EN
    output logic [DW-1:0] fwd1_data,
    output logic [DW-1:0] fwd2_data,
`endif
    output logic [AW:0]   count
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [RW-1:0] r_reg  [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_mem_acc;
    logic          w_alu_acc;
    logic          w_push;
    logic          w_pop;
    logic [RW-1:0] w_push_reg;
    logic [DW-1:0] w_push_data;

    // Ready depends only on the registered count, so a pop on the same edge
    // never re-opens a full queue within that cycle.
    assign w_full    = (r_count == c_full_count);
    assign mem_ready = ~w_full;
    assign alu_ready = ~w_full & ~mem_valid;

    assign w_mem_acc   = mem_valid & mem_ready;
    assign w_alu_acc   = alu_valid & alu_ready;
    assign w_push_reg  = w_mem_acc ? mem_reg  : alu_reg;
    assign w_push_data = w_mem_acc ? mem_data : alu_data;

    // Writes to r0 are handshaken but dropped: they would never be visible.
    assign w_push = (w_mem_acc | w_alu_acc) & (w_push_reg != '0);
    assign w_pop  = ~hold & (r_count != '0);

    assign count = r_count;

    // ------------------------------------------------------------------
    // Control state and registered output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            regwrite  <= 1'b0;
            writereg  <= '0;
            writedata <= '0;
        end else begin
            regwrite <= w_pop;
            if (w_pop) begin
                writereg  <= r_reg[r_rptr];
                writedata <= r_data[r_rptr];
                r_rptr    <= r_rptr + AW'(1);
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; validity is tracked by the pointers/count, so the
    // payload itself needs no reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_reg[r_wptr]  <= w_push_reg;
            r_data[r_wptr] <= w_push_data;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection: a slot is live when its distance from the read
    // pointer is below the current count.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [AW-1:0] w_off;
        assign w_off       = AW'(gi) - r_rptr;
        assign w_valid[gi] = ({1'b0, w_off} < r_count);
        assign w_hit1[gi]  = w_valid[gi] & (r_reg[gi] == readreg1);
        assign w_hit2[gi]  = w_valid[gi] & (r_reg[gi] == readreg2);
    end

    assign hazard1 = (readreg1 != '0) &
                     ((|w_hit1) | (regwrite & (writereg == readreg1)));
    assign hazard2 = (readreg2 != '0) &
                     ((|w_hit2) | (regwrite & (writereg == readreg2)));

`ifdef WB_BYPASS_EN
    // ------------------------------------------------------------------
    // Forwarding: start from the output stage (oldest pending write) and
    // walk the queue from head to tail so the youngest match wins.
    // ------------------------------------------------------------------
    logic [DW-1:0] w_fwd1;
    logic [DW-1:0] w_fwd2;
    logic [AW-1:0] w_idx;

    always_comb begin
        w_fwd1 = (regwrite && (writereg == readreg1)) ? writedata : '0;
        w_fwd2 = (regwrite && (writereg == readreg2)) ? writedata : '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rptr + AW'(k);
            if ((AW+1)'(k) < r_count) begin
                if (r_reg[w_idx] == readreg1) begin
                    w_fwd1 = r_data[w_idx];
                end
                if (r_reg[w_idx] == readreg2) begin
                    w_fwd2 = r_data[w_idx];
                end
            end
        end
    end

    assign fwd1_data = hazard1 ? w_fwd1 : '0;
    assign fwd2_data = hazard2 ? w_fwd2 : '0;
`endif

endmodule
`default_nettype wire
